// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I pipeline: multi-cycle load/store with configurable
// wait states, little-endian byte lanes, combinational stall request and access-error flag.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic [2:0]  funct3,
    output logic [31:0] mem_data_out,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        mem_err
);
    localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAST_WAIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    logic [31:0] memory [0:DEPTH_WORDS-1];

    state_t      state_r, state_s;
    logic [3:0]  cnt_r;
    logic        rd_r, wr_r;
    logic [31:0] addr_r, wdata_r;
    logic [2:0]  funct3_r;

    logic        op_rd_s, op_wr_s;
    logic [31:0] op_addr_s, op_wdata_s, diff_s, idx_s, word_s, load_s, lanes_s;
    logic [2:0]  op_funct3_s;
    logic [3:0]  be_s;
    logic        err_s, do_access_s;

    function automatic logic access_err(input logic rd, input logic wr, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] idx);
        logic e;
        e = (rd & wr) | (idx >= 32'(DEPTH_WORDS));
        case (f3)
            3'b000:  e = e;
            3'b001:  e = e | a[0];
            3'b010:  e = e | (a[1:0] != 2'b00);
            3'b100,
            3'b101:  e = e | wr | (f3[0] & a[0]);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] f3,
                                                 input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = w;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            3'b000:  be = 4'b0001 << off;
            3'b001:  be = off[1] ? 4'b1100 : 4'b0011;
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] l;
        case (f3)
            3'b000:  l = {4{wd[7:0]}};
            3'b001:  l = {2{wd[15:0]}};
            default: l = wd;
        endcase
        return l;
    endfunction

    // Operands come from the ports in IDLE so a zero-latency access completes on its capture edge.
    always_comb begin
        if (state_r == IDLE) begin
            op_rd_s     = mem_rd;
            op_wr_s     = mem_wr;
            op_addr_s   = addr;
            op_wdata_s  = wr_data;
            op_funct3_s = funct3;
        end else begin
            op_rd_s     = rd_r;
            op_wr_s     = wr_r;
            op_addr_s   = addr_r;
            op_wdata_s  = wdata_r;
            op_funct3_s = funct3_r;
        end
    end

    // Address decode, error check and lane steering for the pending access.
    always_comb begin
        diff_s  = op_addr_s - ADDR_BASE;
        idx_s   = {2'b00, diff_s[31:2]};
        err_s   = access_err(op_rd_s, op_wr_s, op_funct3_s, op_addr_s, idx_s);
        word_s  = memory[idx_s[AW-1:0]];
        load_s  = load_extract(word_s, op_funct3_s, op_addr_s[1:0]);
        be_s    = store_be(op_funct3_s, op_addr_s[1:0]);
        lanes_s = store_lanes(op_funct3_s, op_wdata_s);
    end

    // Next-state logic and combinational stall request.
    always_comb begin
        state_s  = state_r;
        mem_busy = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_rd | mem_wr) begin
                    mem_busy = 1'b1;
                    state_s  = (LATENCY > 0) ? WAIT : RESP;
                end else begin
                    state_s  = IDLE;
                end
            end
            WAIT: begin
                mem_busy = 1'b1;
                if (cnt_r == LAST_WAIT) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    assign do_access_s = (state_s == RESP);

    // State, wait counter, request capture and registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            rd_r         <= 1'b0;
            wr_r         <= 1'b0;
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            funct3_r     <= 3'd0;
            mem_data_out <= 32'd0;
            mem_ready    <= 1'b0;
            mem_err      <= 1'b0;
        end else begin
            state_r   <= state_s;
            mem_ready <= do_access_s;
            mem_err   <= do_access_s & err_s;
            if (state_r == IDLE) begin
                cnt_r <= 4'd0;
                if (mem_rd | mem_wr) begin
                    rd_r     <= mem_rd;
                    wr_r     <= mem_wr;
                    addr_r   <= addr;
                    wdata_r  <= wr_data;
                    funct3_r <= funct3;
                end
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_r + 4'd1;
            end
            if (do_access_s) begin
                if (err_s) begin
                    mem_data_out <= 32'd0;
                end else if (op_rd_s) begin
                    mem_data_out <= load_s;
                end
            end
        end
    end

    // Byte-lane store; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (rst && do_access_s && op_wr_s && !err_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    memory[idx_s[AW-1:0]][8*b +: 8] <= lanes_s[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (zero and three wait states, different
// base addresses) driven by directed and random accesses against a byte-level reference model.
module tb_dmem_responder;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_1000;
    localparam int          LAT0  = 0;
    localparam int          LAT1  = 3;
    localparam int          DEPTH = 256;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       mem_rd, mem_wr;
    logic [1:0][31:0] addr, wr_data;
    logic [1:0][2:0]  funct3;
    wire  [31:0]      dout0, dout1;
    wire              ready0, ready1, busy0, busy1, err0, err1;

    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    logic [31:0] mm [2][DEPTH];
    logic [31:0] last_out [2];
    int          n_tests = 0;
    int          n_fail  = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0), .ADDR_BASE(BASE0)) u_dut0 (
        .clk(clk), .rst(rst), .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]), .addr(addr[0]),
        .wr_data(wr_data[0]), .funct3(funct3[0]), .mem_data_out(dout0), .mem_ready(ready0),
        .mem_busy(busy0), .mem_err(err0));

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1), .ADDR_BASE(BASE1)) u_dut1 (
        .clk(clk), .rst(rst), .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]), .addr(addr[1]),
        .wr_data(wr_data[1]), .funct3(funct3[1]), .mem_data_out(dout1), .mem_ready(ready1),
        .mem_busy(busy1), .mem_err(err1));

    function automatic logic [31:0] f_dout(input int d);
        return (d == 0) ? dout0 : dout1;
    endfunction
    function automatic logic f_ready(input int d);
        return (d == 0) ? ready0 : ready1;
    endfunction
    function automatic logic f_busy(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction
    function automatic logic f_err(input int d);
        return (d == 0) ? err0 : err1;
    endfunction

    function automatic void chk(input string name, input int d, input logic [31:0] act,
                                input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %h, expected %h", name, d, $time, act, exp);
        end
    endfunction

    // Reference model: byte-addressed little-endian memory, RV32I width/sign rules.
    function automatic void model(input int d, input bit rd, input bit wr, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [2:0] f3,
                                  output bit er, output logic [31:0] q);
        logic [31:0] base, idx, w, mask, v;
        int          off, nb;
        bit          sgn, misal;
        base = (d == 0) ? BASE0 : BASE1;
        idx  = (a - base) / 32'd4;
        off  = int'(a % 32'd4);
        nb   = 0;
        sgn  = 1'b0;
        if (rd && !wr) begin
            case (f3)
                3'd0:    begin nb = 1; sgn = 1'b1; end
                3'd1:    begin nb = 2; sgn = 1'b1; end
                3'd2:    nb = 4;
                3'd4:    nb = 1;
                3'd5:    nb = 2;
                default: nb = 0;
            endcase
        end else if (wr && !rd) begin
            case (f3)
                3'd0:    nb = 1;
                3'd1:    nb = 2;
                3'd2:    nb = 4;
                default: nb = 0;
            endcase
        end
        misal = (nb != 0) && ((off % ((nb == 0) ? 1 : nb)) != 0);
        er    = (nb == 0) || misal || (idx >= 32'(DEPTH));
        if (er) begin
            q           = 32'd0;
            last_out[d] = 32'd0;
        end else if (rd) begin
            w    = mm[d][idx[7:0]];
            v    = w >> (8 * off);
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
            v    = v & mask;
            if (sgn && v[8*nb-1]) v = v | ~mask;
            q           = v;
            last_out[d] = v;
        end else begin
            w = mm[d][idx[7:0]];
            for (int i = 0; i < nb; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
            mm[d][idx[7:0]] = w;
            q = last_out[d];
        end
    endfunction

    function automatic void check_resp(input int d);
        exp_t e;
        int   sz;
        sz = (d == 0) ? exp_q0.size() : exp_q1.size();
        n_tests++;
        if (sz == 0) begin
            n_fail++;
            $display("FAIL spurious_ready dut%0d @%0t: got ready=1, expected no response", d, $time);
        end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk("resp_data", d, f_dout(d), e.data);
            chk("resp_err", d, 32'(f_err(d)), 32'(e.err));
        end
    endfunction

    // Monitor: every ready pulse is matched against the oldest expected response.
    always @(negedge clk) begin
        if (ready0 === 1'b1) check_resp(0);
        if (ready1 === 1'b1) check_resp(1);
    end

    task automatic garbage(input int d);
        mem_rd[d]  = 1'($urandom_range(0, 1));
        mem_wr[d]  = 1'($urandom_range(0, 1));
        addr[d]    = $urandom;
        wr_data[d] = $urandom;
        funct3[d]  = 3'($urandom_range(0, 7));
    endtask

    // Entered and left just after a rising edge; checks busy/ready timing cycle by cycle.
    task automatic issue(input int d, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3);
        exp_t        e;
        bit          er;
        logic [31:0] q;
        int          lat;
        lat = (d == 0) ? LAT0 : LAT1;
        model(d, rd, wr, a, wd, f3, er, q);
        e.data = q;
        e.err  = er;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        mem_rd[d] = rd; mem_wr[d] = wr; addr[d] = a; wr_data[d] = wd; funct3[d] = f3;
        @(negedge clk);
        chk("busy_req", d, 32'(f_busy(d)), 32'd1);
        chk("ready_req", d, 32'(f_ready(d)), 32'd0);
        for (int k = 0; k < lat; k++) begin
            @(posedge clk); #1; garbage(d);
            @(negedge clk);
            chk("busy_wait", d, 32'(f_busy(d)), 32'd1);
            chk("ready_wait", d, 32'(f_ready(d)), 32'd0);
        end
        @(posedge clk); #1; garbage(d);
        @(negedge clk);
        chk("ready_resp", d, 32'(f_ready(d)), 32'd1);
        chk("busy_resp", d, 32'(f_busy(d)), 32'd0);
        mem_rd[d] = 1'b0; mem_wr[d] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_after", d, 32'(f_ready(d)), 32'd0);
        chk("busy_after", d, 32'(f_busy(d)), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic rand_op(input int d);
        int          sel, where;
        bit          rd, wr;
        logic [31:0] base, a;
        logic [2:0]  f3;
        base  = (d == 0) ? BASE0 : BASE1;
        sel   = $urandom_range(0, 99);
        rd    = (sel < 50);
        wr    = (sel >= 45);
        where = $urandom_range(0, 19);
        if (where < 17) begin
            a = base + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
        end else if (where < 19) begin
            a = base + 32'h400 + 32'($urandom_range(0, 65535));
        end else begin
            a = base - 32'($urandom_range(1, 64));
        end
        f3 = 3'($urandom_range(0, 7));
        issue(d, rd, wr, a, $urandom, f3);
    endtask

    task automatic check_idle_outputs(input string name, input int d);
        chk({name, "_data"}, d, f_dout(d), 32'd0);
        chk({name, "_ready"}, d, 32'(f_ready(d)), 32'd0);
        chk({name, "_err"}, d, 32'(f_err(d)), 32'd0);
        chk({name, "_busy"}, d, 32'(f_busy(d)), 32'd0);
    endtask

    initial begin
        rst = 1'b0; mem_rd = '0; mem_wr = '0; addr = '0; wr_data = '0; funct3 = '0;
        for (int d = 0; d < 2; d++) begin
            last_out[d] = 32'd0;
            for (int i = 0; i < DEPTH; i++) mm[d][i] = 32'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset", 0);
        check_idle_outputs("reset", 1);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++)
                issue(d, 1'b0, 1'b1, ((d == 0) ? BASE0 : BASE1) + 32'(4 * i), $urandom, 3'b010);
        end

        // Zero-latency instance: word, sub-word, byte-lane store and error cases.
        issue(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
        issue(0, 1'b0, 1'b1, 32'h10, 32'h8070_F0FF, 3'b010);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b000);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b100);
        issue(0, 1'b1, 1'b0, 32'h12, 32'h0, 3'b001);
        issue(0, 1'b1, 1'b0, 32'h12, 32'h0, 3'b101);
        issue(0, 1'b0, 1'b1, 32'h10, 32'h1122_3344, 3'b010);
        issue(0, 1'b0, 1'b1, 32'h13, 32'h0000_00AA, 3'b000);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
        issue(0, 1'b0, 1'b1, 32'h12, 32'h5555_5555, 3'b010);
        issue(0, 1'b1, 1'b0, 32'h400, 32'h0, 3'b010);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
        issue(0, 1'b1, 1'b1, 32'h14, 32'h0, 3'b010);
        for (int n = 0; n < 150; n++) rand_op(0);

        // Three-wait-state instance with a non-zero base.
        issue(1, 1'b1, 1'b0, BASE1 + 32'h10, 32'h0, 3'b010);
        issue(1, 1'b1, 1'b0, BASE1 - 32'h4, 32'h0, 3'b010);
        issue(1, 1'b1, 1'b0, BASE1 + 32'h400, 32'h0, 3'b010);

        // Reset in the second wait cycle discards the pending store.
        mem_wr[1] = 1'b1; mem_rd[1] = 1'b0; addr[1] = BASE1 + 32'h20;
        wr_data[1] = 32'h5A5A_A5A5; funct3[1] = 3'b010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; mem_wr[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        last_out[0] = 32'd0;
        last_out[1] = 32'd0;
        @(negedge clk);
        check_idle_outputs("abort", 1);
        chk("abort_data", 0, f_dout(0), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        issue(1, 1'b1, 1'b0, BASE1 + 32'h20, 32'h0, 3'b010);
        for (int n = 0; n < 100; n++) rand_op(1);

        repeat (4) @(posedge clk);
        chk("pending_q", 0, 32'(exp_q0.size()), 32'd0);
        chk("pending_q", 1, 32'(exp_q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32i pipeline. It answers the load/store requests that the EX/MEM stage issues, and returns read data on `mem_data_out`. It models a configurable number of wait states and drives a stall request back to the pipeline. It implements all RV32I load/store widths, little-endian, and flags misaligned or out-of-range accesses. The word array is named `memory` so benches can preload it with `$readmemb`.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words in the array.
- `LATENCY`, 1: wait-state cycles inserted before each access completes (legal 0..15).
- `ADDR_BASE`, 32'h0000_0000: byte address mapped to `memory[0]`.

- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `mem_rd`  in  1: load request (EX/MEM `mem_rd_out`).
- `mem_wr`  in  1: store request (EX/MEM `mem_wr_out`).
- `addr`  in  32: byte address (EX/MEM `ula_res_out`).
- `wr_data`  in  32: store data (EX/MEM `val_B_out`).
- `funct3`  in  3: access width/sign, RV32I encoding.
- `mem_data_out`  out  32: load result; holds its value until the next completed load.
- `mem_ready`  out  1: one-cycle pulse when the access completes.
- `mem_busy`  out  1: stall request to the pipeline.
- `mem_err`  out  1: pulses with `mem_ready` when the access was rejected.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if `mem_rd|mem_wr` is high, capture `addr`, `wr_data`, `funct3` and op. Go to WAIT if `LATENCY`>0, otherwise go to RESP. The counter is cleared on capture.
- WAIT: the counter increments each cycle. Go to RESP when counter == `LATENCY`-1.
- RESP: `mem_ready`=1 for exactly one cycle, then go to IDLE unconditionally.
- Inputs that change after capture are ignored until the FSM returns to IDLE.
- The access is performed on the clock edge that enters RESP:
  - Store: byte-lane write into `memory`.
  - Load: `mem_data_out` is registered on that edge.
- Loads, byte lanes selected by `addr[1:0]`:
  - 000 LB: sign-extend.
  - 001 LH: sign-extend.
  - 010 LW.
  - 100 LBU: zero-extend.
  - 101 LHU: zero-extend.
- Stores:
  - 000 SB: writes lane `addr[1:0]` only.
  - 001 SH: writes lanes `addr[1]*2` and +1.
  - 010 SW: writes all four lanes.
- Word index = (`addr`-`ADDR_BASE`)>>2, computed in 32-bit unsigned arithmetic.
- Error conditions; any one sets `mem_err`=1 in RESP:
  - Misaligned halfword (`addr[0]`=1).
  - Misaligned word (`addr[1:0]`≠0).
  - Index ≥ `DEPTH_WORDS`, including `addr`<`ADDR_BASE` (wraps to a large value).
  - Unsupported `funct3`: loads 011/110/111, stores ≥011.
  - `mem_rd` and `mem_wr` both high.
- On error: no array write, `mem_data_out` is set to 0, and the latency is the same as a normal access.
- `mem_busy` = (IDLE and (`mem_rd|mem_wr`)) or WAIT. This is combinational so the pipeline stalls in the request cycle. It is 0 in RESP.

## Timing
- Request present in IDLE at cycle N → `mem_ready` (and `mem_data_out` valid for loads) at cycle N+1+`LATENCY`.
- `mem_busy` is high cycles N..N+`LATENCY`. It is low in the RESP cycle so the pipeline advances on that edge.
- A new request is accepted no earlier than the cycle after RESP. Back-to-back throughput is one access per `LATENCY`+2 cycles.
- A request still asserted in the RESP cycle is not re-captured. The FSM returns to IDLE first, and the requester is responsible for dropping or advancing the request.
- Reset values, applied on the edge with `rst`=0:
  - State IDLE, counter 0.
  - `mem_data_out`=0, `mem_ready`=0, `mem_err`=0.
  - `mem_busy` follows its equation (0 with no request).
- `memory` contents are not cleared by reset.
- Reset mid-WAIT or in RESP aborts the access. A store that has not yet reached the RESP edge is discarded; a store that has already reached it stays written.

## Test plan
- `LATENCY`=0, SW `addr`=0x10 `wr_data`=0xDEADBEEF, then LW 0x10 → `mem_ready` one cycle after each request, `mem_data_out`=0xDEADBEEF, `mem_busy` high exactly 1 cycle per access.
- Preload word 4 = 0x8070_F0FF:
  - LB 0x10 → 0xFFFFFFFF.
  - LBU 0x10 → 0x000000FF.
  - LH 0x12 → 0xFFFF8070.
  - LHU 0x12 → 0x00008070.
- SB `addr`=0x13 `wr_data`=0xAA into word 0x11223344, then LW 0x10 → 0xAA223344.
- `LATENCY`=3, LW at cycle 10 → `mem_busy` high cycles 10–13, `mem_ready` at cycle 14 only, inputs changed at cycle 11 are ignored.
- SW at 0x12 (misaligned), then LW 0x400 with `DEPTH_WORDS`=256 → `mem_err`=1 and `mem_data_out`=0 on both, array unchanged.
- SW 0x20 with `LATENCY`=3, `rst`=0 at cycle 2 of WAIT → FSM returns to IDLE, word 8 unchanged, all outputs 0.
